// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants and helpers for the common data bus arbiter.
//   REG_DAT_W      - architectural result width
//   ROB_ADD_W      - ROB tag width (tag 0 = no dependency)
//   CDB_FIFO_DEPTH - per-producer result FIFO depth
//   CDB_SRC_EX/LSB - encoding of the winning source on oCDB_Src
package cdb_arbiter_pkg;

    localparam int   REG_DAT_W      = 32;
    localparam int   ROB_ADD_W      = 5;
    localparam int   CDB_FIFO_DEPTH = 4;
    localparam logic CDB_SRC_EX     = 1'b0;
    localparam logic CDB_SRC_LSB    = 1'b1;

    // Two-way round robin: LSB wins when it alone requests, or when both
    // request and EX was the previous winner.
    function automatic logic rr_pick_lsb(input logic ex_req,
                                         input logic lsb_req,
                                         input logic last_grant);
        return lsb_req & (!ex_req | (last_grant == CDB_SRC_EX));
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer/consumer side signals of the CDB arbiter.
//   en, iFlush          - global enable and misprediction flush
//   iEX_*  / oEX_Full   - EX result push (En, Qd tag, Vd value) and full flag
//   iLSB_* / oLSB_Full  - LSB result push and full flag
//   oCDB_*              - registered broadcast (En, Qd, Vd, Src)
// Modports: master = environment driving results, slave = the arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int TAG_W = ROB_ADD_W,
    parameter int DAT_W = REG_DAT_W
);
    logic             en;
    logic             iFlush;
    logic             iEX_En;
    logic [TAG_W-1:0] iEX_Qd;
    logic [DAT_W-1:0] iEX_Vd;
    logic             oEX_Full;
    logic             iLSB_En;
    logic [TAG_W-1:0] iLSB_Qd;
    logic [DAT_W-1:0] iLSB_Vd;
    logic             oLSB_Full;
    logic             oCDB_En;
    logic [TAG_W-1:0] oCDB_Qd;
    logic [DAT_W-1:0] oCDB_Vd;
    logic             oCDB_Src;

    modport master (
        output en, iFlush,
        output iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
        input  oEX_Full, oLSB_Full, oCDB_En, oCDB_Qd, oCDB_Vd, oCDB_Src
    );

    modport slave (
        input  en, iFlush,
        input  iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
        output oEX_Full, oLSB_Full, oCDB_En, oCDB_Qd, oCDB_Vd, oCDB_Src
    );

endinterface

// File: rtl/cdb_fifo.sv
// cdb_fifo: small synchronous FIFO with async active-high reset and sync clear.
//   clk, rst    - clock, asynchronous active-high reset
//   clr         - synchronous clear (wins over push/pop)
//   push, din   - write; ignored while full
//   pop         - read; ignored while empty
//   full, empty - decoded from the registered count only
//   head        - entry at the read pointer (valid when !empty)
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges EX and LSB results onto one registered common data bus.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - cdb_arbiter_if.slave: en, iFlush, EX/LSB push ports with full
//              flags, and the oCDB_En/Qd/Vd/Src broadcast
// Each producer has a private cdb_fifo; one result per enabled cycle is popped
// with round-robin priority. Build option CDB_BYPASS_EN lets a push into an
// empty, winning source go straight to the broadcast register (1-edge latency).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int TAG_W      = ROB_ADD_W,
    parameter int DAT_W      = REG_DAT_W,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int EW = TAG_W + DAT_W;
`ifdef CDB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic          ex_full, ex_empty, lsb_full, lsb_empty;
    logic [EW-1:0] ex_head, lsb_head, ex_in, lsb_in, win_ent;
    logic          act, clr;
    logic          ex_req, lsb_req, ex_cand, lsb_cand;
    logic          win_lsb, any_win, ex_byp, lsb_byp;
    logic          ex_push, lsb_push, ex_pop, lsb_pop;
    logic          last_grant;
    logic          cdb_vld_p0, cdb_src_p0;
    logic [TAG_W-1:0] cdb_qd_p0;
    logic [DAT_W-1:0] cdb_vd_p0;

    assign act   = bus.en & !bus.iFlush;
    assign clr   = bus.en & bus.iFlush;
    assign ex_in  = {bus.iEX_Qd, bus.iEX_Vd};
    assign lsb_in = {bus.iLSB_Qd, bus.iLSB_Vd};

    // A push is only real with a nonzero tag into a FIFO that was not full.
    assign ex_req  = bus.iEX_En  & (bus.iEX_Qd  != '0) & !ex_full;
    assign lsb_req = bus.iLSB_En & (bus.iLSB_Qd != '0) & !lsb_full;

    // Arbitration sees registered FIFO state; with bypass an incoming push
    // also counts as a head for an otherwise empty source.
    assign ex_cand  = !ex_empty  | (BYPASS & ex_req);
    assign lsb_cand = !lsb_empty | (BYPASS & lsb_req);
    assign win_lsb  = rr_pick_lsb(ex_cand, lsb_cand, last_grant);
    assign any_win  = ex_cand | lsb_cand;

    assign ex_byp  = BYPASS & any_win & !win_lsb & ex_empty;
    assign lsb_byp = BYPASS & win_lsb & lsb_empty;

    assign ex_pop   = act & any_win & !win_lsb & !ex_empty;
    assign lsb_pop  = act & win_lsb & !lsb_empty;
    assign ex_push  = act & ex_req  & !ex_byp;
    assign lsb_push = act & lsb_req & !lsb_byp;

    always_comb begin
        win_ent = ex_head;
        if (win_lsb) win_ent = lsb_byp ? lsb_in : lsb_head;
        else         win_ent = ex_byp  ? ex_in  : ex_head;
    end

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_ex_fifo (
        .clk(clk), .rst(rst), .clr(clr), .push(ex_push), .pop(ex_pop),
        .din(ex_in), .full(ex_full), .empty(ex_empty), .head(ex_head)
    );

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_lsb_fifo (
        .clk(clk), .rst(rst), .clr(clr), .push(lsb_push), .pop(lsb_pop),
        .din(lsb_in), .full(lsb_full), .empty(lsb_empty), .head(lsb_head)
    );

    // ---- stage p0: registered broadcast ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_vld_p0 <= 1'b0;
            cdb_qd_p0  <= '0;
            cdb_vd_p0  <= '0;
            cdb_src_p0 <= CDB_SRC_EX;
            last_grant <= CDB_SRC_LSB;
        end else if (bus.en) begin
            if (bus.iFlush) begin
                cdb_vld_p0 <= 1'b0;
                cdb_qd_p0  <= '0;
                cdb_vd_p0  <= '0;
                cdb_src_p0 <= CDB_SRC_EX;
                last_grant <= CDB_SRC_LSB;
            end else if (any_win) begin
                cdb_vld_p0 <= 1'b1;
                {cdb_qd_p0, cdb_vd_p0} <= win_ent;
                cdb_src_p0 <= win_lsb;
                last_grant <= win_lsb;
            end else begin
                cdb_vld_p0 <= 1'b0;
            end
        end
    end

    assign bus.oEX_Full  = ex_full;
    assign bus.oLSB_Full = lsb_full;
    assign bus.oCDB_En   = cdb_vld_p0;
    assign bus.oCDB_Qd   = cdb_qd_p0;
    assign bus.oCDB_Vd   = cdb_vd_p0;
    assign bus.oCDB_Src  = cdb_src_p0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed test of cdb_arbiter in its default build
// (CDB_BYPASS_EN undefined, 2-edge push-to-broadcast latency).
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    cdb_arbiter_if #(.TAG_W(5), .DAT_W(32)) bus ();

    cdb_arbiter #(.TAG_W(5), .DAT_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        bus.iFlush  = 1'b0;
        bus.iEX_En  = 1'b0; bus.iEX_Qd  = '0; bus.iEX_Vd  = '0;
        bus.iLSB_En = 1'b0; bus.iLSB_Qd = '0; bus.iLSB_Vd = '0;
    endtask

    task automatic do_flush;
        bus.iFlush = 1'b1;
        tick();
        bus.iFlush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.en = 1'b0; clear_in();
        repeat (2) tick();
        n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", bus.oCDB_En); end
        n_tests++; if (bus.oCDB_Qd !== 5'd0) begin n_fail++; $display("FAIL reset_qd got %0d want 0", bus.oCDB_Qd); end
        n_tests++; if (bus.oCDB_Vd !== 32'd0) begin n_fail++; $display("FAIL reset_vd got %h want 0", bus.oCDB_Vd); end
        n_tests++; if (bus.oCDB_Src !== 1'b0) begin n_fail++; $display("FAIL reset_src got %b want 0", bus.oCDB_Src); end
        rst = 1'b0; bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.oCDB_En !== 1'b0 || bus.oCDB_Qd !== 5'd0 || bus.oCDB_Vd !== 32'd0)
                begin n_fail++; $display("FAIL idle_cdb got en=%b qd=%0d vd=%h want 0/0/0", bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Vd); end
            n_tests++; if (bus.oEX_Full !== 1'b0 || bus.oLSB_Full !== 1'b0)
                begin n_fail++; $display("FAIL idle_full got ex=%b lsb=%b want 0/0", bus.oEX_Full, bus.oLSB_Full); end
        end
    endtask

    task automatic test_single_push;
        bus.iEX_En = 1'b1; bus.iEX_Qd = 5'd3; bus.iEX_Vd = 32'h1234_5678;
        tick();
        clear_in();
        n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL single_early got en=%b want 0", bus.oCDB_En); end
        tick();
        n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== 5'd3 || bus.oCDB_Vd !== 32'h1234_5678 || bus.oCDB_Src !== 1'b0)
            begin n_fail++; $display("FAIL single_bcast got en=%b qd=%0d vd=%h src=%b want 1/3/12345678/0", bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Vd, bus.oCDB_Src); end
        tick();
        n_tests++; if (bus.oCDB_En !== 1'b0 || bus.oCDB_Qd !== 5'd3)
            begin n_fail++; $display("FAIL single_pulse got en=%b qd=%0d want 0/3", bus.oCDB_En, bus.oCDB_Qd); end
    endtask

    task automatic test_contention;
        logic [4:0] exp_qd  [4] = '{5'd1, 5'd9, 5'd2, 5'd10};
        logic       exp_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_vd;
        do_flush();
        bus.iEX_En = 1'b1; bus.iEX_Qd = 5'd1; bus.iEX_Vd = 32'hE000_0001;
        bus.iLSB_En = 1'b1; bus.iLSB_Qd = 5'd9; bus.iLSB_Vd = 32'hB000_0009;
        tick();
        bus.iEX_Qd = 5'd2; bus.iEX_Vd = 32'hE000_0002;
        bus.iLSB_Qd = 5'd10; bus.iLSB_Vd = 32'hB000_000A;
        tick();
        clear_in();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            exp_vd = (exp_src[k] ? 32'hB000_0000 : 32'hE000_0000) | {27'd0, exp_qd[k]};
            n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== exp_qd[k] || bus.oCDB_Src !== exp_src[k] || bus.oCDB_Vd !== exp_vd)
                begin n_fail++; $display("FAIL contention_%0d got en=%b qd=%0d src=%b vd=%h want 1/%0d/%b/%h", k, bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Src, bus.oCDB_Vd, exp_qd[k], exp_src[k], exp_vd); end
        end
        tick();
        n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL contention_end got en=%b want 0", bus.oCDB_En); end
    endtask

    // Both producers push every cycle; round robin drains EX at half rate so
    // EX fills at edge 7 and its push of tag 30 at edge 8 is dropped.
    task automatic test_full;
        logic [4:0]  exp_qd;
        logic        exp_src;
        logic [31:0] exp_vd;
        logic        saw30 = 1'b0;
        do_flush();
        for (int cyc = 1; cyc <= 15; cyc++) begin
            bus.iEX_En  = (cyc <= 8);
            bus.iEX_Qd  = (cyc <= 7) ? 5'(cyc) : 5'd30;
            bus.iEX_Vd  = 32'hE000_0000 | {27'd0, bus.iEX_Qd};
            bus.iLSB_En = (cyc <= 6);
            bus.iLSB_Qd = 5'(16 + cyc);
            bus.iLSB_Vd = 32'hB000_0000 | {27'd0, bus.iLSB_Qd};
            tick();
            if (bus.oCDB_En === 1'b1 && bus.oCDB_Qd === 5'd30) saw30 = 1'b1;
            if (cyc == 6) begin
                n_tests++; if (bus.oLSB_Full !== 1'b1 || bus.oEX_Full !== 1'b0)
                    begin n_fail++; $display("FAIL full_e6 got ex=%b lsb=%b want 0/1", bus.oEX_Full, bus.oLSB_Full); end
            end
            if (cyc == 7) begin
                n_tests++; if (bus.oEX_Full !== 1'b1 || bus.oLSB_Full !== 1'b0)
                    begin n_fail++; $display("FAIL full_e7 got ex=%b lsb=%b want 1/0", bus.oEX_Full, bus.oLSB_Full); end
            end
            if (cyc == 8) begin
                n_tests++; if (bus.oEX_Full !== 1'b0)
                    begin n_fail++; $display("FAIL full_e8 got ex=%b want 0", bus.oEX_Full); end
            end
            if (cyc >= 2 && cyc <= 14) begin
                exp_src = cyc[0];
                exp_qd  = exp_src ? 5'(16 + (cyc - 1) / 2) : 5'(cyc / 2);
                exp_vd  = (exp_src ? 32'hB000_0000 : 32'hE000_0000) | {27'd0, exp_qd};
                n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== exp_qd || bus.oCDB_Src !== exp_src || bus.oCDB_Vd !== exp_vd)
                    begin n_fail++; $display("FAIL full_seq_%0d got en=%b qd=%0d src=%b vd=%h want 1/%0d/%b/%h", cyc, bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Src, bus.oCDB_Vd, exp_qd, exp_src, exp_vd); end
            end
            if (cyc == 15) begin
                n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL full_drain got en=%b want 0", bus.oCDB_En); end
            end
        end
        clear_in();
        n_tests++; if (saw30 !== 1'b0) begin n_fail++; $display("FAIL full_dropped got tag30_seen=%b want 0", saw30); end
    endtask

    task automatic test_tag_zero_en;
        do_flush();
        bus.iEX_En = 1'b1; bus.iEX_Qd = 5'd0; bus.iEX_Vd = 32'hDEAD_BEEF;
        tick();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL tag0_%0d got en=%b want 0", i, bus.oCDB_En); end
        end
        bus.en = 1'b0; bus.iEX_En = 1'b1; bus.iEX_Qd = 5'd7; bus.iEX_Vd = 32'h7777_7777;
        tick();
        clear_in(); bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL en_low_push_%0d got en=%b want 0", i, bus.oCDB_En); end
        end
        bus.iEX_En = 1'b1; bus.iEX_Qd = 5'd5; bus.iEX_Vd = 32'h0000_0055;
        tick();
        clear_in();
        tick();
        n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== 5'd5)
            begin n_fail++; $display("FAIL freeze_pre got en=%b qd=%0d want 1/5", bus.oCDB_En, bus.oCDB_Qd); end
        bus.en = 1'b0; bus.iLSB_En = 1'b1; bus.iLSB_Qd = 5'd12; bus.iLSB_Vd = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== 5'd5 || bus.oCDB_Vd !== 32'h55 || bus.oCDB_Src !== 1'b0)
                begin n_fail++; $display("FAIL freeze_%0d got en=%b qd=%0d vd=%h src=%b want 1/5/55/0", i, bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Vd, bus.oCDB_Src); end
        end
        clear_in(); bus.en = 1'b1;
        tick();
        n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL freeze_release got en=%b want 0", bus.oCDB_En); end
    endtask

    task automatic test_flush_mid;
        do_flush();
        for (int i = 0; i < 3; i++) begin
            bus.iEX_En  = 1'b1; bus.iEX_Qd  = 5'(1 + i); bus.iEX_Vd  = 32'(1 + i);
            bus.iLSB_En = 1'b1; bus.iLSB_Qd = 5'(9 + i); bus.iLSB_Vd = 32'(9 + i);
            tick();
        end
        n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== 5'd9)
            begin n_fail++; $display("FAIL flush_pre got en=%b qd=%0d want 1/9", bus.oCDB_En, bus.oCDB_Qd); end
        bus.iFlush = 1'b1; bus.iEX_Qd = 5'd4; bus.iLSB_Qd = 5'd12;
        tick();
        clear_in();
        n_tests++; if (bus.oCDB_En !== 1'b0 || bus.oCDB_Qd !== 5'd0 || bus.oCDB_Vd !== 32'd0 || bus.oCDB_Src !== 1'b0)
            begin n_fail++; $display("FAIL flush_out got en=%b qd=%0d vd=%h src=%b want 0/0/0/0", bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Vd, bus.oCDB_Src); end
        n_tests++; if (bus.oEX_Full !== 1'b0 || bus.oLSB_Full !== 1'b0)
            begin n_fail++; $display("FAIL flush_full got ex=%b lsb=%b want 0/0", bus.oEX_Full, bus.oLSB_Full); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL flush_stale_%0d got en=%b qd=%0d want 0", i, bus.oCDB_En, bus.oCDB_Qd); end
        end
    endtask

    task automatic test_async_reset;
        do_flush();
        bus.iEX_En = 1'b1; bus.iEX_Qd = 5'd6; bus.iEX_Vd = 32'h66;
        bus.iLSB_En = 1'b1; bus.iLSB_Qd = 5'd14; bus.iLSB_Vd = 32'hEE;
        tick();
        bus.iEX_Qd = 5'd7; bus.iLSB_Qd = 5'd15;
        tick();
        clear_in();
        n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== 5'd6)
            begin n_fail++; $display("FAIL areset_pre got en=%b qd=%0d want 1/6", bus.oCDB_En, bus.oCDB_Qd); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.oCDB_En !== 1'b0 || bus.oCDB_Qd !== 5'd0 || bus.oCDB_Vd !== 32'd0 || bus.oCDB_Src !== 1'b0)
            begin n_fail++; $display("FAIL areset_async got en=%b qd=%0d vd=%h src=%b want 0/0/0/0", bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Vd, bus.oCDB_Src); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.oCDB_En !== 1'b0) begin n_fail++; $display("FAIL areset_stale_%0d got en=%b qd=%0d want 0", i, bus.oCDB_En, bus.oCDB_Qd); end
        end
        bus.iEX_En = 1'b1; bus.iEX_Qd = 5'd2; bus.iEX_Vd = 32'h2;
        bus.iLSB_En = 1'b1; bus.iLSB_Qd = 5'd3; bus.iLSB_Vd = 32'h3;
        tick();
        clear_in();
        tick();
        n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== 5'd2 || bus.oCDB_Src !== 1'b0)
            begin n_fail++; $display("FAIL areset_first_tie got en=%b qd=%0d src=%b want 1/2/0", bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Src); end
        tick();
        n_tests++; if (bus.oCDB_En !== 1'b1 || bus.oCDB_Qd !== 5'd3 || bus.oCDB_Src !== 1'b1)
            begin n_fail++; $display("FAIL areset_second got en=%b qd=%0d src=%b want 1/3/1", bus.oCDB_En, bus.oCDB_Qd, bus.oCDB_Src); end
    endtask

    initial begin
        bus.en = 1'b0;
        clear_in();
        test_reset();
        test_single_push();
        test_contention();
        test_full();
        test_tag_zero_en();
        test_flush_mid();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
